// File: rtl/dvp_raw_line_aligner_mc.sv
// rtl/dvp_raw_line_aligner_mc.sv - N-channel lockstep line reader packing DVP FIFO words into one stream
module dvp_raw_line_aligner_mc #(
  parameter int N_CH            = 2,
  parameter int DATA_W          = 8,
  parameter int LVL_W           = 14,
  parameter int LINE_LEN        = 1280,
  parameter int LINES_PER_FRAME = 720,
  parameter int THRESH          = 1000,
  parameter int TIMEOUT         = 65535
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [N_CH*LVL_W-1:0]      fifo_lvl,
  input  logic [N_CH*(DATA_W+2)-1:0] fifo_q,
  output logic [N_CH-1:0]            fifo_rdreq,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [N_CH*DATA_W-1:0]     out_data,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic [7:0]                 frame_cnt,
  output logic [9:0]                 line_cnt,
  output logic [N_CH-1:0]            err_align,
  output logic                       err_timeout,
  input  logic                       err_clr
);
  localparam int BEAT_W = $clog2(LINE_LEN + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int PIX_W  = N_CH * DATA_W;
  localparam int ENT_W  = PIX_W + 3;

  typedef enum logic [1:0] {S_WAIT, S_READ, S_CHECK} state_t;
  state_t state, state_nxt;

  logic [N_CH-1:0]   en_r, hit, sof_v, eol_v, align_set;
  logic [PIX_W-1:0]  pix_v;
  logic              all_rdy, any_rdy, partial, to_hit, issue, inflight;
  logic              beat0, last, fs_now, cur_fs, line_fs_r, push, pop;
  logic [BEAT_W-1:0] issued, wr_cnt;
  logic [TMR_W-1:0]  timer;
  logic [9:0]        cur_idx;
  logic [ENT_W-1:0]  ent, head;
  logic [ENT_W-1:0]  mem [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        buf_cnt;

  always_comb begin
    hit   = '0;
    sof_v = '0;
    eol_v = '0;
    pix_v = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i]                    = fifo_lvl[i*LVL_W +: LVL_W] >= LVL_W'(THRESH);
      pix_v[i*DATA_W +: DATA_W] = en_r[i] ? fifo_q[i*(DATA_W+2) +: DATA_W] : '0;
      sof_v[i]                  = fifo_q[i*(DATA_W+2) + DATA_W];
      eol_v[i]                  = fifo_q[i*(DATA_W+2) + DATA_W + 1];
    end
  end

  assign all_rdy = &(~ch_en | hit);
  assign any_rdy = |(ch_en & hit);
  assign partial = any_rdy & ~all_rdy;
  assign to_hit  = (state == S_WAIT) && partial && (timer == TMR_W'(TIMEOUT));

  // Keep at most 3 words owed to the 4-deep buffer so a stalled sink never overflows it
  assign issue = (state == S_READ) && ((buf_cnt + {2'b00, inflight}) <= 3'd2) &&
                 (issued < BEAT_W'(LINE_LEN));
  assign fifo_rdreq = issue ? en_r : '0;

  assign beat0   = (wr_cnt == '0);
  assign last    = (wr_cnt == BEAT_W'(LINE_LEN - 1));
  assign fs_now  = beat0 && (|(en_r & sof_v));
  assign cur_fs  = beat0 ? fs_now : line_fs_r;
  assign cur_idx = cur_fs ? 10'd0 : line_cnt;

  assign align_set = !inflight ? '0 :
                     ((fs_now ? (en_r & ~sof_v) : '0) |
                      (last ? (en_r & ~eol_v) : (en_r & eol_v)));
  assign ent = {fs_now, last, last && (cur_idx == 10'(LINES_PER_FRAME - 1)), pix_v};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (all_rdy && (ch_en != '0)) state_nxt = S_READ;
      S_READ:  if (inflight && last) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      en_r        <= '0;
      issued      <= '0;
      wr_cnt      <= '0;
      timer       <= '0;
      inflight    <= 1'b0;
      line_fs_r   <= 1'b0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
      err_align   <= '0;
      err_timeout <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == S_WAIT) begin
        en_r   <= ch_en;
        issued <= '0;
        wr_cnt <= '0;
        timer  <= (partial && !to_hit) ? timer + 1'b1 : '0;
      end else begin
        timer <= '0;
        if (issue)    issued <= issued + 1'b1;
        if (inflight) wr_cnt <= wr_cnt + 1'b1;
      end
      if (inflight && beat0) line_fs_r <= fs_now;
      if (state == S_CHECK) begin
        if (line_fs_r) frame_cnt <= frame_cnt + 8'd1;
        line_cnt <= (cur_idx == 10'(LINES_PER_FRAME - 1)) ? 10'd0 : cur_idx + 10'd1;
      end
      err_align   <= err_clr ? '0 : (err_align | align_set);
      err_timeout <= err_clr ? 1'b0 : (err_timeout | to_hit);
    end
  end

  // Flags ride in the buffer entry alongside the pixels: {sof, eol, eof, data}
  assign push = inflight;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= ent;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      buf_cnt <= buf_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  assign out_valid = (buf_cnt != 3'd0);
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head[PIX_W-1:0];
  assign out_eof   = head[PIX_W];
  assign out_eol   = head[PIX_W+1];
  assign out_sof   = head[PIX_W+2];
endmodule
